// File: rtl/iterative_shift_unit.sv
// ==== iterative_shift_unit : multi-cycle ARM-style LSL/LSR/ASR/ROR/RRX shifter, STEP bits/cycle ====
// ==== rev 1.0                                                                                  ====
`default_nettype none

module iterative_shift_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int AMT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amt,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int IDX_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_LSL = 3'd0;
   localparam logic [2:0] OP_LSR = 3'd1;
   localparam logic [2:0] OP_ASR = 3'd2;
   localparam logic [2:0] OP_ROR = 3'd3;
   localparam logic [2:0] OP_RRX = 3'd4;

   logic [1:0]       state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] work;
   logic             carry;
   logic             zero_carry;
   logic [CNT_W-1:0] remaining;

   logic [31:0]      amt_ext;
   logic [31:0]      amt_mod;
   logic [CNT_W-1:0] n_init;
   logic [2:0]       op_init;
   logic             carry_init;
   logic             zc_init;

   logic [CNT_W-1:0]        k;
   logic [IDX_W-1:0]        lsl_idx;
   logic [IDX_W-1:0]        lsr_idx;
   logic [WIDTH-1:0]        ror_v;
   logic signed [WIDTH-1:0] asr_v;
   logic [WIDTH-1:0]        shifted;
   logic                    sh_c;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = work;
   assign c_out     = carry;

   // Request decode: shift count and initial carry. Out-of-range LSL/LSR still
   // walk WIDTH steps but must finish with a cleared carry.
   always_comb begin
      amt_ext    = 32'(amt);
      amt_mod    = amt_ext & 32'(WIDTH - 1);
      n_init     = '0;
      op_init    = OP_LSL;
      carry_init = c_in;
      zc_init    = 1'b0;
      case (op)
         OP_LSL, OP_LSR, OP_ASR: begin
            op_init = op;
            if (amt_ext >= 32'(WIDTH)) begin
               n_init  = CNT_W'(WIDTH);
               zc_init = (op != OP_ASR) && (amt_ext > 32'(WIDTH));
            end else begin
               n_init = CNT_W'(amt_ext);
            end
         end
         OP_ROR: begin
            op_init = OP_ROR;
            n_init  = CNT_W'(amt_mod);
            if (amt_ext != 32'd0 && amt_mod == 32'd0)
               carry_init = data_in[WIDTH-1];
         end
         OP_RRX: begin
            op_init = OP_RRX;
            n_init  = CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      k       = (remaining > CNT_W'(STEP)) ? CNT_W'(STEP) : remaining;
      lsl_idx = IDX_W'(CNT_W'(WIDTH) - k);
      lsr_idx = IDX_W'(k - CNT_W'(1));
      ror_v   = (work >> k) | (work << (CNT_W'(WIDTH) - k));
      asr_v   = $signed(work) >>> k;
      shifted = work;
      sh_c    = carry;
      case (op_q)
         OP_LSL: begin shifted = work << k;  sh_c = work[lsl_idx]; end
         OP_LSR: begin shifted = work >> k;  sh_c = work[lsr_idx]; end
         OP_ASR: begin shifted = asr_v;      sh_c = work[lsr_idx]; end
         OP_ROR: begin shifted = ror_v;      sh_c = ror_v[WIDTH-1]; end
         OP_RRX: begin shifted = {carry, work[WIDTH-1:1]}; sh_c = work[0]; end
         default: ;
      endcase
      if (zero_carry)
         sh_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= OP_LSL;
         work       <= '0;
         carry      <= 1'b0;
         zero_carry <= 1'b0;
         remaining  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q       <= op_init;
                  work       <= data_in;
                  carry      <= carry_init;
                  zero_carry <= zc_init;
                  remaining  <= n_init;
                  state      <= (n_init == '0) ? S_DONE : S_SHIFT;
               end
            end
            S_SHIFT: begin
               work      <= shifted;
               carry     <= sh_c;
               remaining <= remaining - k;
               if (remaining == k)
                  state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ==== tb_iterative_shift_unit : random + directed check of iterative_shift_unit (STEP=1 and STEP=8) ====
// ==== rev 1.0                                                                                        ====
`default_nettype none

module tb_iterative_shift_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [2:0]  op;
   logic [31:0] data_in;
   logic [7:0]  amt;
   logic        c_in;
   logic        out_ready;

   logic        in_ready1, out_valid1, c_out1;
   logic [31:0] result1;
   logic        in_ready8, out_valid8, c_out8;
   logic [31:0] result8;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   iterative_shift_unit #(.WIDTH(32), .STEP(1), .AMT_W(8)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .op(op), .data_in(data_in), .amt(amt), .c_in(c_in),
      .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .c_out(c_out1)
   );

   iterative_shift_unit #(.WIDTH(32), .STEP(8), .AMT_W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
      .op(op), .data_in(data_in), .amt(amt), .c_in(c_in),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8), .c_out(c_out8)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Architectural reference: result, carry and shift count straight from the shift rules.
   function automatic void model(input logic [2:0] o, input logic [31:0] d, input int unsigned a,
                                 input logic ci, output logic [31:0] r, output logic co, output int n);
      int unsigned m;
      r = d; co = ci; n = 0;
      case (o)
         3'd0: begin
            n = (a > 32) ? 32 : int'(a);
            if (a == 0) ;
            else if (a < 32) begin r = d << a; co = d[32-a]; end
            else if (a == 32) begin r = 0; co = d[0]; end
            else begin r = 0; co = 1'b0; end
         end
         3'd1: begin
            n = (a > 32) ? 32 : int'(a);
            if (a == 0) ;
            else if (a < 32) begin r = d >> a; co = d[a-1]; end
            else if (a == 32) begin r = 0; co = d[31]; end
            else begin r = 0; co = 1'b0; end
         end
         3'd2: begin
            n = (a > 32) ? 32 : int'(a);
            if (a == 0) ;
            else if (a < 32) begin r = 32'($signed(d) >>> a); co = d[a-1]; end
            else begin r = {32{d[31]}}; co = d[31]; end
         end
         3'd3: begin
            m = a % 32;
            n = int'(m);
            if (a == 0) ;
            else if (m == 0) co = d[31];
            else begin r = (d >> m) | (d << (32 - m)); co = r[31]; end
         end
         3'd4: begin r = {ci, d[31:1]}; co = d[0]; n = 1; end
         default: ;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [7:0] a,
                         input logic ci, input bit stall);
      logic [31:0] er, r1, r8;
      logic        ec, cr1, cr8;
      int          n, lat, l1, l8;
      bit          seen1, seen8;
      model(o, d, int'(a), ci, er, ec, n);
      @(negedge clk);
      out_ready = !stall;
      op = o; data_in = d; amt = a; c_in = ci; in_valid = 1'b1;
      check("in_ready1", 64'(in_ready1), 64'd1);
      check("in_ready8", 64'(in_ready8), 64'd1);
      seen1 = 0; seen8 = 0; lat = 0; l1 = 0; l8 = 0;
      r1 = '0; r8 = '0; cr1 = 0; cr8 = 0;
      while (!(seen1 && seen8) && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            in_valid = 1'b0;
            data_in = $urandom; amt = 8'($urandom); c_in = ~ci; op = 3'($urandom);
         end
         if (out_valid1 && !seen1) begin seen1 = 1; r1 = result1; cr1 = c_out1; l1 = lat; end
         if (out_valid8 && !seen8) begin seen8 = 1; r8 = result8; cr8 = c_out8; l8 = lat; end
      end
      check("done1", 64'(seen1), 64'd1);
      check("done8", 64'(seen8), 64'd1);
      check("result1", 64'(r1), 64'(er));
      check("c_out1", 64'(cr1), 64'(ec));
      check("latency1", 64'(l1), 64'((n == 0) ? 1 : 1 + n));
      check("result8", 64'(r8), 64'(er));
      check("c_out8", 64'(cr8), 64'(ec));
      check("latency8", 64'(l8), 64'((n == 0) ? 1 : 1 + (n + 7) / 8));
      if (stall) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid1), 64'd1);
            check("stall_ready", 64'(in_ready1), 64'd0);
            check("stall_result", 64'(result1), 64'(er));
            check("stall_c_out", 64'(c_out1), 64'(ec));
         end
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("release_valid", 64'(out_valid1), 64'd0);
         check("release_ready", 64'(in_ready1), 64'd1);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [2:0] ro;
      logic [7:0] ra;
      reset = 1'b1; in_valid = 1'b0; op = '0; data_in = '0; amt = '0; c_in = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid1), 64'd0);
      check("rst_result", 64'(result1), 64'd0);
      check("rst_c_out", 64'(c_out1), 64'd0);
      check("rst_out_valid8", 64'(out_valid8), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready1), 64'd1);

      run_op(3'd0, 32'h8000_0001, 8'd1,  1'b0, 0);
      run_op(3'd1, 32'h8000_0000, 8'd32, 1'b0, 0);
      run_op(3'd1, 32'h8000_0000, 8'd33, 1'b1, 0);
      run_op(3'd0, 32'h8000_0001, 8'd32, 1'b0, 0);
      run_op(3'd0, 32'h8000_0001, 8'd33, 1'b1, 0);
      run_op(3'd2, 32'h8000_0000, 8'd40, 1'b0, 0);
      run_op(3'd3, 32'h0000_00F1, 8'd4,  1'b1, 0);
      run_op(3'd3, 32'h8000_1234, 8'd64, 1'b0, 0);
      run_op(3'd4, 32'h0000_0003, 8'd77, 1'b1, 0);
      run_op(3'd0, 32'h1234_5678, 8'd0,  1'b1, 0);
      run_op(3'd6, 32'hCAFE_F00D, 8'd9,  1'b1, 0);
      run_op(3'd0, 32'h0F0F_1111, 8'd20, 1'b0, 0);
      run_op(3'd1, 32'hA5A5_5A5A, 8'd7,  1'b0, 1);

      // Abort a long shift with reset; nothing may come out afterwards.
      @(negedge clk);
      op = 3'd0; data_in = 32'hFFFF_FFFF; amt = 8'd20; c_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_valid", 64'(out_valid1), 64'd0);
      check("mid_ready", 64'(in_ready1), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_valid", 64'(out_valid1), 64'd0);
      check("abort_result", 64'(result1), 64'd0);
      check("abort_c_out", 64'(c_out1), 64'd0);
      check("abort_ready", 64'(in_ready1), 64'd1);
      check("abort_result8", 64'(result8), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_out", 64'(out_valid1), 64'd0);

      for (int t = 0; t < 60; t++) begin
         ro = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 4))
            0: ra = 8'd0;
            1: ra = 8'($urandom_range(1, 31));
            2: ra = 8'(32 * $urandom_range(1, 7));
            3: ra = 8'($urandom_range(32, 34));
            default: ra = 8'($urandom);
         endcase
         run_op(ro, $urandom, ra, 1'($urandom), (t % 15) == 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
